// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the serializer state encoding and the elaboration-time helper used by the buffer.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_e;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte push handshake into the transmit buffer.
// The producer drives data/valid and the buffer answers with ready.
interface uart_tx_buffered_if;

    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with show-ahead read data and registered full/empty/level.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Status flags are computed from the next pointers so they are valid straight out of a flop.
    always_comb begin
        do_push  = push_i && !full_q;
        do_pop   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        level_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed from a small byte FIFO.
// The serializer pops the next byte on the STOP boundary so frames run back to back.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_tx_buffered_if.slave             in_if,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int                CNT_W    = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_buffered: CLKS_PER_BIT must be at least 2");
    end

    uart_tx_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic             bit_done;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_if.valid_i),
        .wdata_i (in_if.data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign in_if.ready_o = !fifo_full;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        bit_done  = (cnt_q == CNT_MAX);

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is decoded from the next state so tx changes on the same edge as the FSM.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != IDLE) || (level_o != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomized scoreboard bench for uart_tx_buffered: a timing model predicts when each byte
// starts on the line, and an independent line decoder checks every frame against it.
module tb_uart_tx_buffered;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             tx_o;
    logic             busy_o;
    logic [LVL_W-1:0] level_o;

    uart_tx_buffered_if bus ();

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_if   (bus),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .level_o (level_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int pop;
    } hist_t;

    typedef struct {
        logic [7:0] data;
        int         pop;
    } exp_t;

    hist_t hist[$];
    exp_t  sb[$];
    int    cyc = 0;
    int    lineFree = 0;
    int    nCompared = 0;
    int    nFailed = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a byte occupies the buffer from its accepting edge until its pop edge, and the line until pop+FRAME.
    function automatic int modelLevel(input int k);
        int n = 0;
        foreach (hist[i]) if (hist[i].acc <= k && hist[i].pop > k) n++;
        return n;
    endfunction

    function automatic bit modelBusy(input int k);
        foreach (hist[i]) if (hist[i].pop + FRAME > k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput();
        int lvl;
        bit bsy;
        lvl = modelLevel(cyc);
        bsy = modelBusy(cyc);
        checkVal("level", level_o, lvl);
        checkVal("ready", bus.ready_o, (lvl < DEPTH));
        checkVal("busy", busy_o, bsy);
        if (!bsy) checkVal("idle_line", tx_o, 1);
    endtask

    // One clock cycle: offer a byte, let the model decide acceptance, then check at the falling edge.
    task automatic applyStimulus(input bit v, input logic [7:0] d);
        bit acc;
        int p;
        bus.valid_i = v;
        bus.data_i  = d;
        acc = v && rst_n && (modelLevel(cyc) < DEPTH);
        @(posedge clk);
        cyc++;
        if (acc) begin
            p = (cyc + 1 > lineFree) ? cyc + 1 : lineFree;
            lineFree = p + FRAME;
            hist.push_back('{acc: cyc, pop: p});
            sb.push_back('{data: d, pop: p});
        end
        while (hist.size() > 0 && hist[0].pop + FRAME <= cyc) void'(hist.pop_front());
        @(negedge clk);
        bus.valid_i = 1'b0;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic drain(input int maxCyc);
        int n = 0;
        while (modelBusy(cyc) && n < maxCyc) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        if (n >= maxCyc) begin
            nCompared++;
            nFailed++;
            $display("[TB] FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
        end
        idle(4);
        checkVal("drain_empty", sb.size(), 0);
    endtask

    task automatic flushModel();
        hist.delete();
        sb.delete();
        lineFree = 0;
    endtask

    // Line decoder: finds the start bit, samples mid-bit, and pops the scoreboard on the stop bit.
    initial begin : monitor
        int         mCnt;
        int         b;
        bit         inFrame;
        logic [7:0] rxByte;
        int         startCyc;
        exp_t       e;
        mCnt = 0; b = 0; inFrame = 1'b0; rxByte = '0; startCyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inFrame = 1'b0;
            end else if (!inFrame) begin
                if (tx_o === 1'b0) begin
                    inFrame  = 1'b1;
                    mCnt     = 0;
                    startCyc = cyc;
                end
            end else begin
                mCnt++;
                if (mCnt >= CPB / 2 && ((mCnt - CPB / 2) % CPB) == 0) begin
                    b = (mCnt - CPB / 2) / CPB;
                    if (b == 0) begin
                        checkVal("start_bit", tx_o, 0);
                    end else if (b <= 8) begin
                        rxByte[b-1] = tx_o;
                    end else begin
                        inFrame = 1'b0;
                        checkVal("stop_bit", tx_o, 1);
                        if (sb.size() == 0) begin
                            nCompared++;
                            nFailed++;
                            $display("[TB] FAIL unexpected_frame: got byte %0h starting cycle %0d, expected no frame", rxByte, startCyc);
                        end else begin
                            e = sb.pop_front();
                            checkVal("rx_data", rxByte, e.data);
                            checkVal("start_cycle", startCyc, e.pop);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int target;
        int lows;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;

        // Asynchronous reset must take effect before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        checkVal("reset_tx", tx_o, 1);
        checkVal("reset_ready", bus.ready_o, 1);
        checkVal("reset_busy", busy_o, 0);
        checkVal("reset_level", level_o, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] single byte 0x55");
        applyStimulus(1'b1, 8'h55);
        drain(400);

        $display("[TB] overfill with 0x00..0x09");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i));
        checkVal("full_level", level_o, 8);
        checkVal("full_ready", bus.ready_o, 0);
        drain(2000);

        $display("[TB] back-to-back 0x00, 0xFF");
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        drain(600);

        $display("[TB] push on the stop-to-start pop edge");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA0 + 8'(i));
        target = sb[1].pop;
        while (cyc < target - 1) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'hC3);
        checkVal("level_hold", level_o, 3);
        drain(1200);

        $display("[TB] random traffic");
        for (int i = 0; i < 120; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom));
        end
        drain(4000);

        $display("[TB] reset during data bit 3");
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);
        target = sb[0].pop + CPB + 3 * CPB + CPB / 2;
        while (cyc < target) applyStimulus(1'b0, 8'h00);
        #2 rst_n = 1'b0;
        flushModel();
        #1;
        checkVal("midreset_tx", tx_o, 1);
        checkVal("midreset_level", level_o, 0);
        checkVal("midreset_ready", bus.ready_o, 1);
        checkVal("midreset_busy", busy_o, 0);
        idle(3);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, 8'h00);
            if (tx_o !== 1'b1) lows++;
        end
        checkVal("quiet_after_reset", lows, 0);

        $display("[TB] push on first edge after reset release");
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h3C);
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
